dds_sweep_ctrl: RTL and testbench
=================================

Name: dds_sweep_ctrl

Overview:
Frequency-sweep scheduler that drives the tuning-word, phase-offset and enable inputs of the DDS core.
- Host loads a sweep configuration through a valid/ready handshake.
- On `start`, the block steps the DDS frequency from a start word to a stop word in fixed increments, holding each point for a programmable dwell.
- Supports single-shot and continuous (auto-repeat) modes, pause via `hold`, and `abort`.

Parameters:
- PW, 32: tuning-word / phase width; matches the DDS phase-accumulator width.
- CW, 16: dwell counter width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- cfg_valid  in  1  config offer
- cfg_ready  out  1  config accepted when cfg_valid & cfg_ready
- cfg_start_freq  in  PW  first tuning word (unsigned)
- cfg_stop_freq  in  PW  last tuning word (unsigned)
- cfg_step  in  PW  step magnitude (unsigned)
- cfg_dwell  in  CW  extra cycles per point; each point lasts dwell+1 cycles
- cfg_phase  in  PW  static phase offset passed to the DDS
- cfg_cont  in  1  0 = single-shot, 1 = continuous
- start  in  1  begin sweep (sampled in IDLE only)
- abort  in  1  terminate sweep
- hold  in  1  pause sweep; current point is kept
- dds_en  out  1  DDS enable
- dds_freq  out  PW  DDS tuning word
- dds_phase  out  PW  DDS phase offset
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse at the natural end of a single-shot sweep

Behaviour:
- Reset (async, any time): state = IDLE.
  - All config registers clear to 0.
  - dds_en = 0, dds_freq = 0, dds_phase = 0, busy = 0, done = 0.
  - cfg_ready = 1 once out of reset.
- States: IDLE, RUN. cfg_ready = (state == IDLE).
- Config capture:
  - A handshake in IDLE registers all cfg_* fields.
  - cfg_valid is ignored in RUN.
- Start:
  - `start` in IDLE causes RUN on the next cycle.
  - If a config handshake occurs in the same cycle, the newly offered config is used.
  - With no config ever loaded, the reset-default config runs: one point at freq 0, dwell 0.
- Timing from a `start` cycle N:
  - Cycle N+1: dds_en = 1, dds_freq = start_freq, dds_phase = cfg_phase, busy = 1.
  - The dwell counter is loaded with cfg_dwell.
- In RUN, when hold = 0:
  - If dwell counter > 0, decrement it.
  - If dwell counter = 0 and cur ≠ stop: advance to the next point and reload the dwell counter.
  - If dwell counter = 0 and cur = stop: the sweep has ended (see end-of-sweep below).
- Next-point arithmetic:
  - Direction: up if stop ≥ start (unsigned compare), else down.
  - rem = |stop − cur|, computed at PW bits with no overflow.
  - If step = 0 or step ≥ rem: next = stop (clamp; the stop point is never overshot).
  - Otherwise next = cur ± step.
- Hold:
  - While hold = 1 in RUN, the dwell counter and dds_freq freeze and dds_en stays 1.
  - hold has no effect in IDLE.
- End of sweep (dwell counter = 0, cur = stop, hold = 0):
  - cfg_cont = 0: next cycle state = IDLE, dds_en = 0, busy = 0, and done = 1 for exactly that one cycle.
  - dds_freq retains the stop value.
  - cfg_cont = 1: next cycle dds_freq = start_freq with the dwell counter reloaded; stays in RUN with no gap and no done pulse.
- Abort:
  - abort in RUN means next cycle IDLE, dds_en = 0, busy = 0, no done pulse.
  - abort has priority over hold and end-of-sweep.
  - abort in IDLE is ignored.
  - abort and start in the same IDLE cycle: start wins.
- Degenerate case start = stop: a single point of dwell+1 cycles.
  - Then done (single-shot), or the point repeats indefinitely (continuous).
- All outputs are registered; no combinational path from inputs to outputs, except cfg_ready, which is decoded from the state register.

Test Plan:
- Up sweep: start = 100, stop = 130, step = 10, dwell = 2, single-shot.
  - dds_freq = 100 ×3, 110 ×3, 120 ×3, 130 ×3 with dds_en = 1 for 12 cycles.
  - Then dds_en = 0 and done high for exactly 1 cycle; dds_freq stays 130.
- Down sweep with clamp: start = 50, stop = 20, step = 20, dwell = 0.
  - dds_freq = 50, 30, 20, then done.
  - Repeat with step = 0: dds_freq = 50, 20, then done.
- Continuous: start = 0, stop = 2, step = 1, dwell = 0, cfg_cont = 1.
  - dds_freq = 0, 1, 2, 0, 1, 2, … with no dds_en gap and done never asserted.
- Hold/abort: in the up-sweep case, assert hold for 5 cycles at point 110.
  - 110 lasts 8 cycles total.
  - Then abort during 120: next cycle dds_en = 0, busy = 0, done = 0, cfg_ready = 1.
- Handshake: cfg_valid in RUN is not accepted (cfg_ready = 0) and the config is unchanged.
  - cfg_valid together with start in IDLE: the first point equals the new cfg_start_freq on the next cycle.
- Reset mid-sweep: assert rst asynchronously between clock edges during RUN.
  - All outputs go to 0 immediately.
  - After release, start with no new config: one point at freq 0, then done.

Source files
------------

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep scheduler for a DDS core: steps the tuning word from a start
// to a stop value with a per-point dwell, in single-shot or continuous mode.
module dds_sweep_ctrl #(
  parameter int unsigned PW = 32,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [PW-1:0] cfg_start_freq,
  input  logic [PW-1:0] cfg_stop_freq,
  input  logic [PW-1:0] cfg_step,
  input  logic [CW-1:0] cfg_dwell,
  input  logic [PW-1:0] cfg_phase,
  input  logic          cfg_cont,
  input  logic          start,
  input  logic          abort,
  input  logic          hold,
  output logic          dds_en,
  output logic [PW-1:0] dds_freq,
  output logic [PW-1:0] dds_phase,
  output logic          busy,
  output logic          done
);

  localparam logic S_IDLE = 1'b0;
  localparam logic S_RUN  = 1'b1;

  logic          state_q,   state_d;
  logic [PW-1:0] start_q,   start_d;
  logic [PW-1:0] stop_q,    stop_d;
  logic [PW-1:0] step_q,    step_d;
  logic [CW-1:0] dwell_q,   dwell_d;
  logic [PW-1:0] phase_q,   phase_d;
  logic          cont_q,    cont_d;
  logic [CW-1:0] cnt_q,     cnt_d;
  logic          en_q,      en_d;
  logic [PW-1:0] freq_q,    freq_d;
  logic [PW-1:0] dphase_q,  dphase_d;
  logic          busy_q,    busy_d;
  logic          done_q,    done_d;

  logic          dir_up;
  logic [PW-1:0] rem;
  logic [PW-1:0] next_pt;

  // Next sweep point, clamped so the stop word is never overshot
  always_comb begin
    dir_up = (stop_q >= start_q);
    rem    = dir_up ? (stop_q - freq_q) : (freq_q - stop_q);
    if ((step_q == '0) || (step_q >= rem)) begin
      next_pt = stop_q;
    end else if (dir_up) begin
      next_pt = freq_q + step_q;
    end else begin
      next_pt = freq_q - step_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    start_d  = start_q;
    stop_d   = stop_q;
    step_d   = step_q;
    dwell_d  = dwell_q;
    phase_d  = phase_q;
    cont_d   = cont_q;
    cnt_d    = cnt_q;
    en_d     = en_q;
    freq_d   = freq_q;
    dphase_d = dphase_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cfg_valid) begin
          start_d = cfg_start_freq;
          stop_d  = cfg_stop_freq;
          step_d  = cfg_step;
          dwell_d = cfg_dwell;
          phase_d = cfg_phase;
          cont_d  = cfg_cont;
        end
        // A config offered in the start cycle takes effect immediately
        if (start) begin
          state_d  = S_RUN;
          en_d     = 1'b1;
          busy_d   = 1'b1;
          freq_d   = cfg_valid ? cfg_start_freq : start_q;
          dphase_d = cfg_valid ? cfg_phase      : phase_q;
          cnt_d    = cfg_valid ? cfg_dwell      : dwell_q;
        end
      end

      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
          en_d    = 1'b0;
          busy_d  = 1'b0;
        end else if (!hold) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
          end else if (freq_q != stop_q) begin
            freq_d = next_pt;
            cnt_d  = dwell_q;
          end else if (cont_q) begin
            freq_d = start_q;
            cnt_d  = dwell_q;
          end else begin
            state_d = S_IDLE;
            en_d    = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        en_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      start_q  <= '0;
      stop_q   <= '0;
      step_q   <= '0;
      dwell_q  <= '0;
      phase_q  <= '0;
      cont_q   <= 1'b0;
      cnt_q    <= '0;
      en_q     <= 1'b0;
      freq_q   <= '0;
      dphase_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      stop_q   <= stop_d;
      step_q   <= step_d;
      dwell_q  <= dwell_d;
      phase_q  <= phase_d;
      cont_q   <= cont_d;
      cnt_q    <= cnt_d;
      en_q     <= en_d;
      freq_q   <= freq_d;
      dphase_q <= dphase_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign cfg_ready = (state_q == S_IDLE);
  assign dds_en    = en_q;
  assign dds_freq  = freq_q;
  assign dds_phase = dphase_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed scoreboard bench for dds_sweep_ctrl: expected per-cycle outputs are
// queued when a sweep is launched and compared as the DUT produces them.
module tb_dds_sweep_ctrl;

  localparam int unsigned PW = 32;
  localparam int unsigned CW = 16;

  typedef struct packed {
    logic          en;
    logic          done;
    logic          fchk;
    logic [PW-1:0] freq;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [PW-1:0] cfg_start_freq;
  logic [PW-1:0] cfg_stop_freq;
  logic [PW-1:0] cfg_step;
  logic [CW-1:0] cfg_dwell;
  logic [PW-1:0] cfg_phase;
  logic          cfg_cont;
  logic          start;
  logic          abort;
  logic          hold;
  logic          dds_en;
  logic [PW-1:0] dds_freq;
  logic [PW-1:0] dds_phase;
  logic          busy;
  logic          done;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  dds_sweep_ctrl #(.PW(PW), .CW(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .cfg_start_freq (cfg_start_freq),
    .cfg_stop_freq  (cfg_stop_freq),
    .cfg_step       (cfg_step),
    .cfg_dwell      (cfg_dwell),
    .cfg_phase      (cfg_phase),
    .cfg_cont       (cfg_cont),
    .start          (start),
    .abort          (abort),
    .hold           (hold),
    .dds_en         (dds_en),
    .dds_freq       (dds_freq),
    .dds_phase      (dds_phase),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input logic [PW-1:0] s, input logic [PW-1:0] p, input logic [PW-1:0] st,
                         input logic [CW-1:0] dw, input logic [PW-1:0] ph, input logic c);
    cfg_start_freq = s;
    cfg_stop_freq  = p;
    cfg_step       = st;
    cfg_dwell      = dw;
    cfg_phase      = ph;
    cfg_cont       = c;
  endtask

  task automatic push_pt(input logic [PW-1:0] f, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e = '{en: 1'b1, done: 1'b0, fchk: 1'b1, freq: f};
      sb.push_back(e);
    end
  endtask

  // Natural single-shot end: one done cycle, then quiet, freq held at stop
  task automatic push_end(input logic [PW-1:0] f);
    exp_t e;
    e = '{en: 1'b0, done: 1'b1, fchk: 1'b1, freq: f};
    sb.push_back(e);
    e = '{en: 1'b0, done: 1'b0, fchk: 1'b1, freq: f};
    sb.push_back(e);
  endtask

  task automatic push_abort();
    exp_t e;
    e = '{en: 1'b0, done: 1'b0, fchk: 1'b0, freq: '0};
    sb.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("dds_en", PW'(dds_en), PW'(e.en));
      chk("busy",   PW'(busy),   PW'(e.en));
      chk("done",   PW'(done),   PW'(e.done));
      if (e.fchk) chk("dds_freq", dds_freq, e.freq);
    end
  endtask

  task automatic drain();
    int guard = 0;
    while (sb.size() > 0 && guard < 200) begin
      tick();
      guard++;
    end
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout observed=%0d expected=0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    rst = 1'b1;
    cfg_valid = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    hold  = 1'b0;
    set_cfg('0, '0, '0, '0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;

    // Reset state
    chk("rst_en",    PW'(dds_en),    '0);
    chk("rst_freq",  dds_freq,       '0);
    chk("rst_phase", dds_phase,      '0);
    chk("rst_busy",  PW'(busy),      '0);
    chk("rst_done",  PW'(done),      '0);
    chk("rst_ready", PW'(cfg_ready), PW'(1));

    // Up sweep: config loaded first, then start
    set_cfg(100, 130, 10, 2, 32'h1234, 1'b0);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    chk("idle_ready", PW'(cfg_ready), PW'(1));
    start = 1'b1;
    push_pt(100, 3); push_pt(110, 3); push_pt(120, 3); push_pt(130, 3); push_end(130);
    tick();
    start = 1'b0;
    chk("up_phase", dds_phase, 32'h1234);
    chk("run_ready", PW'(cfg_ready), '0);
    drain();

    // Down sweep with clamp; config offered in the start cycle
    set_cfg(50, 20, 20, 0, 0, 1'b0);
    cfg_valid = 1'b1;
    start = 1'b1;
    push_pt(50, 1); push_pt(30, 1); push_pt(20, 1); push_end(20);
    tick();
    cfg_valid = 1'b0;
    start = 1'b0;
    drain();

    // Step 0 jumps straight to stop; abort alongside start is ignored
    cfg_step = 0;
    cfg_valid = 1'b1;
    start = 1'b1;
    abort = 1'b1;
    push_pt(50, 1); push_pt(20, 1); push_end(20);
    tick();
    cfg_valid = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    drain();

    // Continuous wrap, with a config offer in RUN that must be ignored
    set_cfg(0, 2, 1, 0, 32'h55, 1'b1);
    cfg_valid = 1'b1;
    start = 1'b1;
    for (int r = 0; r < 3; r++) begin
      push_pt(0, 1); push_pt(1, 1); push_pt(2, 1);
    end
    tick();
    start = 1'b0;
    set_cfg(500, 900, 7, 3, 32'h99, 1'b0);
    #1;
    chk("run_ready_offer", PW'(cfg_ready), '0);
    drain();
    cfg_valid = 1'b0;
    abort = 1'b1;
    push_abort();
    tick();
    abort = 1'b0;
    chk("abort_ready", PW'(cfg_ready), PW'(1));
    start = 1'b1;
    push_pt(0, 1); push_pt(1, 1); push_pt(2, 1); push_pt(0, 1);
    tick();
    start = 1'b0;
    chk("cfg_kept_phase", dds_phase, 32'h55);
    drain();
    abort = 1'b1;
    push_abort();
    tick();
    abort = 1'b0;

    // Hold for 5 cycles at 110, then abort during 120
    set_cfg(100, 130, 10, 2, 0, 1'b0);
    cfg_valid = 1'b1;
    start = 1'b1;
    push_pt(100, 3); push_pt(110, 8); push_pt(120, 1); push_abort();
    tick();
    cfg_valid = 1'b0;
    start = 1'b0;
    tick();
    tick();
    tick();
    hold = 1'b1;
    repeat (5) tick();
    hold = 1'b0;
    repeat (3) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("hold_abort_ready", PW'(cfg_ready), PW'(1));
    chk("hold_abort_left", sb.size(), '0);

    // Asynchronous reset mid-sweep, then run on reset-default config
    cfg_valid = 1'b1;
    start = 1'b1;
    tick();
    cfg_valid = 1'b0;
    start = 1'b0;
    tick();
    #3;
    rst = 1'b1;
    #1;
    chk("arst_en",    PW'(dds_en), '0);
    chk("arst_freq",  dds_freq,    '0);
    chk("arst_phase", dds_phase,   '0);
    chk("arst_busy",  PW'(busy),   '0);
    chk("arst_done",  PW'(done),   '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("post_rst_ready", PW'(cfg_ready), PW'(1));
    start = 1'b1;
    push_pt(0, 1); push_end(0);
    tick();
    start = 1'b0;
    chk("default_phase", dds_phase, '0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
